// File: rtl/restoring_divider_8bit_if.sv
// Switch-bus / Run front end and result outputs of the 8-bit restoring divider.
// The master drives operands and Run; the slave (divider) returns results and status.
interface restoring_divider_8bit_if;
  logic [7:0] din;
  logic       ld_a;
  logic       ld_b;
  logic       run;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  modport master (
    output din, ld_a, ld_b, run,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  din, ld_a, ld_b, run,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/restoring_divider_8bit.sv
// Unsigned 8-bit restoring shift-subtract divider, one quotient bit per clock.
// Operands load from a shared switch bus in IDLE; Run starts an 8-cycle SHIFT phase.
module restoring_divider_8bit (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  restoring_divider_8bit_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] r_q, r_d;
  logic [7:0] q_q, q_d;
  logic [7:0] d_q, d_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dbz_q, dbz_d;

  logic [8:0] trial;
  logic [8:0] diff;
  logic       fits;

  // Partial remainder with the next dividend bit shifted in; R < D holds, so 9 bits suffice.
  assign trial = {r_q, q_q[7]};
  assign diff  = trial - {1'b0, d_q};
  assign fits  = (trial >= {1'b0, d_q});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      r_q     <= 8'd0;
      q_q     <= 8'd0;
      d_q     <= 8'd0;
      cnt_q   <= 3'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.ld_a) a_d = bus.din;
        if (bus.ld_b) b_d = bus.din;
        // Run captures the pre-load operand values even if a load fires on the same edge.
        if (bus.run) begin
          q_d     = a_q;
          r_d     = 8'd0;
          d_d     = b_q;
          cnt_d   = 3'd0;
          dbz_d   = (b_q == 8'd0);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (fits) begin
          r_d = diff[7:0];
          q_d = {q_q[6:0], 1'b1};
        end else begin
          r_d = trial[7:0];
          q_d = {q_q[6:0], 1'b0};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = HOLD;
      end
      HOLD: begin
        if (!bus.run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q;
  assign bus.busy        = (state_q == SHIFT);
  assign bus.done        = (state_q == HOLD);
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Scoreboarded bench for restoring_divider_8bit: directed divides queue their
// expected results; a monitor checks them when Done rises.
module tb_restoring_divider_8bit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  restoring_divider_8bit_if dif();

  restoring_divider_8bit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t exp_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endfunction

  // Monitor: pops one expected result on every rising edge of Done.
  initial begin : monitor
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (dif.done && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("quotient",  {24'd0, dif.quotient},  {24'd0, e.q});
          check("remainder", {24'd0, dif.remainder}, {24'd0, e.r});
          check("div_by_zero", {31'd0, dif.div_by_zero}, {31'd0, e.dbz});
          $display("result Q=%0d R=%0d DBZ=%0b (expected %0d/%0d/%0b)",
                   dif.quotient, dif.remainder, dif.div_by_zero, e.q, e.r, e.dbz);
        end
      end
      done_prev = dif.done;
    end
  end

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dif.ld_a = 1'b1; dif.din = a;
    @(negedge clk);
    dif.ld_a = 1'b0; dif.ld_b = 1'b1; dif.din = b;
    @(negedge clk);
    dif.ld_b = 1'b0; dif.din = 8'd0;
  endtask

  // Raises Run (optionally with an A load on the same edge), counts Busy cycles until Done.
  task automatic start_run(input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                           input logic ld_a_same, input logic [7:0] ld_a_val,
                           input logic ld_b_mid, input logic [7:0] ld_b_val);
    int busy_cycles;
    bit got_done;
    exp_q.push_back('{q: eq, r: er, dbz: edbz});
    @(negedge clk);
    dif.run = 1'b1;
    if (ld_a_same) begin
      dif.ld_a = 1'b1; dif.din = ld_a_val;
    end
    busy_cycles = 0;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      @(posedge clk);
      #1;
      dif.ld_a = 1'b0;
      if (ld_b_mid && dif.busy) begin
        dif.ld_b = 1'b1; dif.din = ld_b_val;
      end
      if (dif.busy) busy_cycles++;
      if (dif.busy && dif.done) check("busy_done_overlap", 32'd1, 32'd0);
      if (dif.done) got_done = 1'b1;
    end
    dif.ld_b = 1'b0;
    check("done_within_bound", {31'd0, got_done}, 32'd1);
    check("busy_cycles", busy_cycles, 32'd8);
  endtask

  task automatic release_run(input logic [7:0] eq, input logic [7:0] er);
    @(negedge clk);
    dif.run = 1'b0;
    @(posedge clk);
    #1;
    check("done_after_release", {31'd0, dif.done}, 32'd0);
    check("idle_hold_values", {16'd0, dif.quotient, dif.remainder}, {16'd0, eq, er});
  endtask

  task automatic divide(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edbz);
    load(a, b);
    start_run(eq, er, edbz, 1'b0, 8'd0, 1'b0, 8'd0);
    release_run(eq, er);
    $display("divide %0d / %0d done", a, b);
  endtask

  initial begin : stimulus
    n_checks = 0;
    n_fail   = 0;
    dif.din = 8'd0; dif.ld_a = 1'b0; dif.ld_b = 1'b0; dif.run = 1'b0;
    rst_n = 1'b0;
    #2;
    check("reset_outputs", {13'd0, dif.quotient, dif.remainder, dif.busy, dif.done, dif.div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic and extreme operands
    divide(8'd100, 8'd7,   8'd14,  8'd2, 1'b0);
    divide(8'd255, 8'd1,   8'd255, 8'd0, 1'b0);
    divide(8'd3,   8'd200, 8'd0,   8'd3, 1'b0);
    divide(8'd255, 8'd255, 8'd1,   8'd0, 1'b0);

    // Zero divisor, then a normal run clears the flag
    divide(8'd5, 8'd0, 8'hFF, 8'd5, 1'b0 | 1'b1);
    divide(8'd9, 8'd3, 8'd3,  8'd0, 1'b0);

    // Ld_B during SHIFT is ignored, and B stays 7 for the next run
    load(8'd100, 8'd7);
    start_run(8'd14, 8'd2, 1'b0, 1'b0, 8'd0, 1'b1, 8'd1);
    release_run(8'd14, 8'd2);
    $display("ld_b during shift: run 1 done");
    start_run(8'd14, 8'd2, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    release_run(8'd14, 8'd2);
    $display("ld_b during shift: run 2 done");

    // Ld_A on the Run edge: this run uses 100, the next uses 50 (50/7 = 7 r 1)
    start_run(8'd14, 8'd2, 1'b0, 1'b1, 8'd50, 1'b0, 8'd0);
    release_run(8'd14, 8'd2);
    start_run(8'd7, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    release_run(8'd7, 8'd1);
    $display("ld_a with run done");

    // Run held through HOLD must not retrigger
    start_run(8'd7, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (!dif.done || dif.busy || dif.quotient != 8'd7 || dif.remainder != 8'd1) bad++;
      end
      check("hold_while_run_high", bad, 32'd0);
    end
    release_run(8'd7, 8'd1);
    start_run(8'd7, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    release_run(8'd7, 8'd1);
    $display("run held / retrigger done");

    // Async reset during iteration 4
    load(8'd100, 8'd7);
    @(negedge clk);
    dif.run = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #3;
    check("busy_before_reset", {31'd0, dif.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {13'd0, dif.quotient, dif.remainder, dif.busy, dif.done, dif.div_by_zero}, 32'd0);
    @(negedge clk);
    dif.run = 1'b0;
    rst_n = 1'b1;
    // Operand registers were cleared: an unloaded run computes 0/0
    start_run(8'hFF, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    release_run(8'hFF, 8'd0);
    divide(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    $display("async reset sequence done");

    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
